// File: rtl/led_blinker_multi_if.sv
// Bundles the per-channel control inputs and status outputs of the
// multi-channel LED driver. The controller drives the mode, run and burst
// fields. The driver returns the LED, busy and done bits.
interface led_blinker_multi_if #(
  parameter int CHANNELS = 4,
  parameter int BURST_W  = 4
);
  logic [2*CHANNELS-1:0]       mode;
  logic [CHANNELS-1:0]         run_n;
  logic [BURST_W*CHANNELS-1:0] burst_len;
  logic [CHANNELS-1:0]         start;
  logic [CHANNELS-1:0]         led;
  logic [CHANNELS-1:0]         busy;
  logic [CHANNELS-1:0]         done;

  modport master (
    output mode, run_n, burst_len, start,
    input  led, busy, done
  );

  modport slave (
    input  mode, run_n, burst_len, start,
    output led, busy, done
  );
endinterface

// File: rtl/led_blinker_multi.sv
// Multi-channel LED driver for the vending-machine status lamps.
// Each channel can be off, steady on, continuously blinking, or running a
// counted burst of blinks that ends with a one-cycle done pulse. All channels
// share one half-period length. An active-low run input per channel freezes
// that channel's blink timing. Every output comes straight from a register.
module led_blinker_multi #(
  parameter int CHANNELS    = 4,
  parameter int CNT_WIDTH   = 32,
  parameter int HALF_PERIOD = 15000000,
  parameter int BURST_W     = 4
) (
  input  logic                clock,
  input  logic                reset_n,
  led_blinker_multi_if.slave  bus
);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_ON    = 2'b01,
    MODE_BLINK = 2'b10,
    MODE_BURST = 2'b11
  } mode_t;

  typedef enum logic {
    PHASE_LOW  = 1'b0,
    PHASE_HIGH = 1'b1
  } phase_t;

  localparam logic [CNT_WIDTH-1:0] LP_CNT_LAST = CNT_WIDTH'(HALF_PERIOD - 1);

  logic [CNT_WIDTH-1:0] r_cnt      [CHANNELS];
  logic [BURST_W-1:0]   r_rem      [CHANNELS];
  phase_t               r_phase    [CHANNELS];
  mode_t                r_prevMode [CHANNELS];
  logic [CHANNELS-1:0]  r_led;
  logic [CHANNELS-1:0]  r_busy;
  logic [CHANNELS-1:0]  r_done;

  mode_t                w_mode     [CHANNELS];
  logic [BURST_W-1:0]   w_len      [CHANNELS];
  logic [CNT_WIDTH-1:0] w_cntNext  [CHANNELS];
  logic [CHANNELS-1:0]  w_halfEnd;

  // Slice the packed input buses per channel, and work out where each counter goes next.
  // A half-period ends only on an enabled cycle that finds the counter at its last value.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      w_mode[i]    = mode_t'(bus.mode[2*i +: 2]);
      w_len[i]     = bus.burst_len[BURST_W*i +: BURST_W];
      w_halfEnd[i] = !bus.run_n[i] && (r_cnt[i] == LP_CNT_LAST);
      w_cntNext[i] = (r_cnt[i] == LP_CNT_LAST) ? '0 : r_cnt[i] + CNT_WIDTH'(1);
    end
  end

  // Per-channel mode handling, blink timing and burst sequencing, all in one registered block.
  // Leaving burst mode always clears busy, so an abort never produces a done pulse.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_cnt[i]      <= '0;
        r_rem[i]      <= '0;
        r_phase[i]    <= PHASE_LOW;
        r_prevMode[i] <= MODE_OFF;
      end
      r_led  <= '0;
      r_busy <= '0;
      r_done <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_done[i]     <= 1'b0;
        r_prevMode[i] <= w_mode[i];
        case (w_mode[i])
          MODE_OFF: begin
            r_led[i]  <= 1'b0;
            r_cnt[i]  <= '0;
            r_busy[i] <= 1'b0;
          end
          MODE_ON: begin
            r_led[i]  <= 1'b1;
            r_cnt[i]  <= '0;
            r_busy[i] <= 1'b0;
          end
          MODE_BLINK: begin
            r_busy[i] <= 1'b0;
            if (r_prevMode[i] != MODE_BLINK) begin
              r_led[i] <= 1'b1;
              r_cnt[i] <= '0;
            end else if (!bus.run_n[i]) begin
              r_cnt[i] <= w_cntNext[i];
              if (w_halfEnd[i]) begin
                r_led[i] <= !r_led[i];
              end
            end
          end
          MODE_BURST: begin
            if (!r_busy[i]) begin
              if (bus.start[i]) begin
                if (w_len[i] != '0) begin
                  r_rem[i]   <= w_len[i];
                  r_busy[i]  <= 1'b1;
                  r_led[i]   <= 1'b1;
                  r_cnt[i]   <= '0;
                  r_phase[i] <= PHASE_HIGH;
                end else begin
                  r_done[i] <= 1'b1;
                end
              end else begin
                r_led[i] <= 1'b0;
                r_cnt[i] <= '0;
              end
            end else if (!bus.run_n[i]) begin
              r_cnt[i] <= w_cntNext[i];
              if (w_halfEnd[i]) begin
                if (r_phase[i] == PHASE_HIGH) begin
                  r_led[i]   <= 1'b0;
                  r_phase[i] <= PHASE_LOW;
                end else if (r_rem[i] > BURST_W'(1)) begin
                  r_rem[i]   <= r_rem[i] - BURST_W'(1);
                  r_led[i]   <= 1'b1;
                  r_phase[i] <= PHASE_HIGH;
                end else begin
                  r_rem[i]  <= '0;
                  r_busy[i] <= 1'b0;
                  r_done[i] <= 1'b1;
                end
              end
            end
          end
        endcase
      end
    end
  end

  assign bus.led  = r_led;
  assign bus.busy = r_busy;
  assign bus.done = r_done;

endmodule

// File: tb/tb_led_blinker_multi.sv
// Testbench for led_blinker_multi with a short half-period.
// A driver applies inputs on the falling edge and pushes the reference model's
// prediction into a queue. A monitor pops one prediction after each rising edge
// and compares it with the outputs. Directed scenarios add checks of the timing
// against fixed expected values.
module tb_led_blinker_multi;

  localparam int CH = 4;
  localparam int HP = 4;
  localparam int BW = 4;
  localparam int CW = 8;

  typedef struct packed {
    logic [CH-1:0] led;
    logic [CH-1:0] busy;
    logic [CH-1:0] done;
  } expect_t;

  logic clock = 1'b0;
  logic resetN;

  logic            drvResetN;
  logic [2*CH-1:0] drvMode;
  logic [CH-1:0]   drvRun;
  logic [BW*CH-1:0] drvLen;
  logic [CH-1:0]   drvStart;

  logic [CH-1:0] obsLed;
  logic [CH-1:0] obsBusy;
  logic [CH-1:0] obsDone;

  int testsRun    = 0;
  int testsFailed = 0;

  expect_t expQ[$];

  // Reference model state: LED level, burst activity, burst halves still to
  // run, enabled cycles left in the current half, and the previous mode.
  int mLed    [CH];
  int mBusy   [CH];
  int mHalves [CH];
  int mLeft   [CH];
  int mPrev   [CH];

  led_blinker_multi_if #(.CHANNELS(CH), .BURST_W(BW)) bus ();

  led_blinker_multi #(
    .CHANNELS    (CH),
    .CNT_WIDTH   (CW),
    .HALF_PERIOD (HP),
    .BURST_W     (BW)
  ) dut (
    .clock   (clock),
    .reset_n (resetN),
    .bus     (bus)
  );

  // Free-running clock with a period of 10 time units.
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Predict the outputs after the next rising edge, using the current drive values.
  task automatic modelCycle();
    expect_t e;
    e = '0;
    if (!drvResetN) begin
      for (int ch = 0; ch < CH; ch++) begin
        mLed[ch] = 0; mBusy[ch] = 0; mHalves[ch] = 0; mLeft[ch] = HP; mPrev[ch] = 0;
      end
    end else begin
      for (int ch = 0; ch < CH; ch++) begin
        int md;
        int len;
        bit runN;
        bit st;
        bit dn;
        md   = int'(drvMode[2*ch +: 2]);
        len  = int'(drvLen[BW*ch +: BW]);
        runN = drvRun[ch];
        st   = drvStart[ch];
        dn   = 1'b0;
        case (md)
          0: begin mLed[ch] = 0; mLeft[ch] = HP; mBusy[ch] = 0; end
          1: begin mLed[ch] = 1; mLeft[ch] = HP; mBusy[ch] = 0; end
          2: begin
            mBusy[ch] = 0;
            if (mPrev[ch] != 2) begin
              mLed[ch] = 1; mLeft[ch] = HP;
            end else if (!runN) begin
              mLeft[ch]--;
              if (mLeft[ch] == 0) begin
                mLeft[ch] = HP;
                mLed[ch] = 1 - mLed[ch];
              end
            end
          end
          default: begin
            if (mBusy[ch] == 0) begin
              if (st) begin
                if (len != 0) begin
                  mBusy[ch] = 1; mHalves[ch] = 2 * len; mLeft[ch] = HP; mLed[ch] = 1;
                end else begin
                  dn = 1'b1;
                end
              end else begin
                mLed[ch] = 0; mLeft[ch] = HP;
              end
            end else if (!runN) begin
              mLeft[ch]--;
              if (mLeft[ch] == 0) begin
                mLeft[ch] = HP;
                mHalves[ch]--;
                if (mHalves[ch] == 0) begin
                  mBusy[ch] = 0; mLed[ch] = 0; dn = 1'b1;
                end else begin
                  mLed[ch] = (mHalves[ch] % 2 == 0) ? 1 : 0;
                end
              end
            end
          end
        endcase
        mPrev[ch] = md;
        e.led[ch]  = (mLed[ch] != 0);
        e.busy[ch] = (mBusy[ch] != 0);
        e.done[ch] = dn;
      end
    end
    expQ.push_back(e);
  endtask

  // One cycle: sample the outputs of the previous cycle, drive new inputs, predict.
  task automatic applyStimulus();
    @(negedge clock);
    obsLed  = bus.led;
    obsBusy = bus.busy;
    obsDone = bus.done;
    resetN        = drvResetN;
    bus.mode      = drvMode;
    bus.run_n     = drvRun;
    bus.burst_len = drvLen;
    bus.start     = drvStart;
    modelCycle();
  endtask

  // Monitor: after each rising edge, compare the outputs with the oldest prediction.
  initial begin
    expect_t e;
    forever begin
      @(posedge clock);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("sb_led",  32'(bus.led),  32'(e.led));
        checkOutput("sb_busy", 32'(bus.busy), 32'(e.busy));
        checkOutput("sb_done", 32'(bus.done), 32'(e.done));
      end
    end
  end

  // Watchdog so the run always ends even if the sequence stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios followed by randomized concurrent traffic.
  initial begin
    logic [23:0] pat;
    logic [23:0] ledPat;
    int   highLen;
    int   busyCnt;
    int   doneCnt;
    int   doneAt;
    bit   riseSeen;
    logic prevLed;

    resetN = 1'b0;
    bus.mode = '0; bus.run_n = '0; bus.burst_len = '0; bus.start = '0;

    // Reset with arbitrary inputs for two cycles.
    drvResetN = 1'b0;
    drvMode = 8'($urandom); drvRun = 4'($urandom); drvLen = 16'($urandom); drvStart = 4'($urandom);
    applyStimulus();
    applyStimulus();
    drvResetN = 1'b1;
    drvMode = 8'b00_00_00_01; drvRun = '0; drvLen = '0; drvStart = '0;
    applyStimulus();
    checkOutput("reset_led",  32'(obsLed),  32'h0);
    checkOutput("reset_busy", 32'(obsBusy), 32'h0);
    checkOutput("reset_done", 32'(obsDone), 32'h0);
    applyStimulus();
    checkOutput("release_led0", 32'(obsLed[0]), 32'h1);

    // Continuous blink on channel 1.
    drvMode[3:2] = 2'b10;
    applyStimulus();
    pat = '0;
    for (int i = 0; i < 24; i++) begin
      applyStimulus();
      pat = {pat[22:0], obsLed[1]};
    end
    checkOutput("blink_pattern", 32'(pat), 32'hF0F0F0);

    // Freeze channel 1 for three cycles in the middle of a high half.
    riseSeen = 1'b0;
    prevLed  = obsLed[1];
    for (int i = 0; i < 16; i++) begin
      applyStimulus();
      if (obsLed[1] && !prevLed) begin
        riseSeen = 1'b1;
        break;
      end
      prevLed = obsLed[1];
    end
    checkOutput("blink_rise_seen", 32'(riseSeen), 32'h1);
    highLen = 1;
    for (int k = 0; k < 12; k++) begin
      drvRun[1] = (k >= 1 && k <= 3);
      applyStimulus();
      if (obsLed[1]) highLen++;
      else break;
    end
    drvRun[1] = 1'b0;
    checkOutput("freeze_high_len", 32'(highLen), 32'd7);

    // Burst of three blinks on channel 2, with a start pulse ignored mid-burst.
    drvLen[11:8] = 4'd3;
    drvMode[5:4] = 2'b11;
    drvStart[2]  = 1'b1;
    applyStimulus();
    busyCnt = 0; doneCnt = 0; doneAt = 0; ledPat = '0;
    for (int j = 1; j <= 30; j++) begin
      drvStart[2] = (j == 10);
      applyStimulus();
      if (obsBusy[2]) busyCnt++;
      if (obsDone[2]) begin
        doneCnt++;
        if (doneAt == 0) doneAt = j;
      end
      if (j <= 24) ledPat = {ledPat[22:0], obsLed[2]};
    end
    drvStart[2] = 1'b0;
    checkOutput("burst_busy_cycles", 32'(busyCnt), 32'd24);
    checkOutput("burst_done_cycle",  32'(doneAt),  32'd25);
    checkOutput("burst_done_count",  32'(doneCnt), 32'd1);
    checkOutput("burst_led_pattern", 32'(ledPat),  32'hF0F0F0);

    // Zero-length burst on channel 3.
    drvLen[15:12] = 4'd0;
    drvMode[7:6]  = 2'b11;
    drvStart[3]   = 1'b1;
    applyStimulus();
    drvStart[3] = 1'b0;
    applyStimulus();
    checkOutput("zero_done",  32'(obsDone[3]), 32'h1);
    checkOutput("zero_busy",  32'(obsBusy[3]), 32'h0);
    checkOutput("zero_led",   32'(obsLed[3]),  32'h0);
    applyStimulus();
    checkOutput("zero_done_clear", 32'(obsDone[3]), 32'h0);

    // Abort a burst on channel 2 by switching it off.
    drvStart[2] = 1'b1;
    applyStimulus();
    drvStart[2] = 1'b0;
    for (int i = 0; i < 6; i++) applyStimulus();
    checkOutput("abort_busy_before", 32'(obsBusy[2]), 32'h1);
    drvMode[5:4] = 2'b00;
    applyStimulus();
    applyStimulus();
    checkOutput("abort_led",  32'(obsLed[2]),  32'h0);
    checkOutput("abort_busy", 32'(obsBusy[2]), 32'h0);
    doneCnt = int'(obsDone[2]);
    for (int i = 0; i < 30; i++) begin
      applyStimulus();
      if (obsDone[2]) doneCnt++;
    end
    checkOutput("abort_no_done", 32'(doneCnt), 32'd0);

    // All channels in different modes with random run, start and length traffic.
    drvMode = 8'b11_10_01_00;
    for (int c = 0; c < 600; c++) begin
      for (int ch = 0; ch < CH; ch++) begin
        if ($urandom_range(0, 31) == 0) drvMode[2*ch +: 2] = 2'($urandom_range(0, 3));
        drvRun[ch]   = ($urandom_range(0, 3) == 0);
        drvStart[ch] = ($urandom_range(0, 5) == 0);
        if (drvStart[ch]) drvLen[BW*ch +: BW] = 4'($urandom_range(0, 5));
      end
      applyStimulus();
    end

    drvStart = '0;
    applyStimulus();
    @(posedge clock);
    #2;
    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
